// File: rtl/dat_sequencer_pkg.sv
// Shared definitions for the SD CMD/DAT controllers: sequencer states and
// the two-bit transfer status codes reported to the host.
package dat_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        WAIT_BLK = 3'd3,
        FINISH   = 3'd4,
        ABORT    = 3'd5,
        ACK_HOST = 3'd6
    } seqState_e;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_TIMEOUT = 2'b01,
        STATUS_CRC_ERR = 2'b10,
        STATUS_REJECT  = 2'b11
    } seqStatus_e;

endpackage

// File: rtl/dat_sequencer_counter.sv
// Clearable up-counter with a terminal-count flag, used as the per-block
// watchdog. hit_o fires on the cycle whose edge brings the count to limit_i.
module dat_sequencer_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         hit_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero limit never hits, which is how the watchdog is disabled.
    assign hit_o   = enable_i && !clear_i && (limit_i != '0) && (count_q == limit_i - W'(1));
    assign count_o = count_q;

endmodule

// File: rtl/dat_sequencer.sv
// DAT-line transfer sequencer: accepts a host request, programs and strobes
// the dat_phys engine, tracks blocks and a watchdog, and reports status.
module dat_sequencer
    import dat_sequencer_pkg::*;
#(
    parameter int BLK_W = 4,
    parameter int TO_W  = 16
) (
    input  logic             sd_clock,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_write,
    input  logic [BLK_W-1:0] req_blocks,
    input  logic [TO_W-1:0]  req_timeout,
    output logic             ack_out,
    output logic [1:0]       status_out,
    output logic             busy_out,
    output logic             strobe_out,
    output logic [BLK_W-1:0] blocks_out,
    output logic             writeRead_out,
    output logic             multiple_out,
    output logic [TO_W-1:0]  timeout_out,
    output logic             ack_phys_out,
    output logic             idle_phys_out,
    input  logic             block_done_in,
    input  logic             crc_err_in
);

    seqState_e        state_q, state_d;
    seqStatus_e       status_q, status_d;
    logic [BLK_W-1:0] blocks_q, blocks_d;
    logic [BLK_W-1:0] blkCnt_q, blkCnt_d;
    logic [BLK_W-1:0] blkCntInc;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic [TO_W-1:0]  wdogCount;
    logic             writeRead_q, writeRead_d;
    logic             multiple_q, multiple_d;
    logic             wdogClear, wdogEnable, wdogHit;

    assign blkCntInc  = blkCnt_q + BLK_W'(1);
    assign wdogClear  = (state_q != WAIT_BLK) || block_done_in;
    assign wdogEnable = (state_q == WAIT_BLK) && (timeout_q != '0);

    dat_sequencer_counter #(
        .W(TO_W)
    ) u_wdog (
        .clk_i    (sd_clock),
        .reset_i  (reset),
        .clear_i  (wdogClear),
        .enable_i (wdogEnable),
        .limit_i  (timeout_q),
        .count_o  (wdogCount),
        .hit_o    (wdogHit)
    );

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        blocks_d    = blocks_q;
        blkCnt_d    = blkCnt_q;
        timeout_d   = timeout_q;
        writeRead_d = writeRead_q;
        multiple_d  = multiple_q;
        unique case (state_q)
            IDLE: begin
                if (req_in) begin
                    if (req_blocks == '0) begin
                        status_d = STATUS_REJECT;
                        state_d  = ACK_HOST;
                    end else begin
                        blocks_d    = req_blocks;
                        writeRead_d = req_write;
                        timeout_d   = req_timeout;
                        multiple_d  = (req_blocks > BLK_W'(1));
                        state_d     = SETUP;
                    end
                end
            end
            SETUP: begin
                blkCnt_d = '0;
                state_d  = STROBE;
            end
            STROBE: state_d = WAIT_BLK;
            // CRC failure beats a coincident block completion, which beats the watchdog.
            WAIT_BLK: begin
                if (crc_err_in) begin
                    status_d = STATUS_CRC_ERR;
                    state_d  = ABORT;
                end else if (block_done_in) begin
                    blkCnt_d = blkCntInc;
                    if (blkCntInc == blocks_q) begin
                        state_d = FINISH;
                    end
                end else if (wdogHit) begin
                    status_d = STATUS_TIMEOUT;
                    state_d  = ABORT;
                end
            end
            FINISH: begin
                status_d = STATUS_OK;
                state_d  = ACK_HOST;
            end
            ABORT: state_d = ACK_HOST;
            ACK_HOST: begin
                if (!req_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            status_q    <= STATUS_OK;
            blocks_q    <= '0;
            blkCnt_q    <= '0;
            timeout_q   <= '0;
            writeRead_q <= 1'b0;
            multiple_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            blocks_q    <= blocks_d;
            blkCnt_q    <= blkCnt_d;
            timeout_q   <= timeout_d;
            writeRead_q <= writeRead_d;
            multiple_q  <= multiple_d;
        end
    end

    // The PHY is held idle combinationally for as long as reset is asserted.
    assign idle_phys_out = reset || (state_q == ABORT);
    assign ack_out       = (state_q == ACK_HOST);
    assign busy_out      = (state_q != IDLE);
    assign strobe_out    = (state_q == STROBE);
    assign ack_phys_out  = (state_q == FINISH);
    assign status_out    = status_q;
    assign blocks_out    = blocks_q;
    assign writeRead_out = writeRead_q;
    assign multiple_out  = multiple_q;
    assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_dat_sequencer.sv
// Directed self-checking bench for dat_sequencer: normal multi-block transfer,
// timeout, CRC abort, zero-block reject, reset mid-transfer and held request.
module tb_dat_sequencer;

    logic        sd_clock;
    logic        reset;
    logic        req_in;
    logic        req_write;
    logic [3:0]  req_blocks;
    logic [15:0] req_timeout;
    logic        ack_out;
    logic [1:0]  status_out;
    logic        busy_out;
    logic        strobe_out;
    logic [3:0]  blocks_out;
    logic        writeRead_out;
    logic        multiple_out;
    logic [15:0] timeout_out;
    logic        ack_phys_out;
    logic        idle_phys_out;
    logic        block_done_in;
    logic        crc_err_in;

    int checks = 0;
    int errors = 0;
    int strobeCnt = 0;
    int ackPhysCnt = 0;
    int idlePhysCnt = 0;

    dat_sequencer #(
        .BLK_W(4),
        .TO_W(16)
    ) dut (
        .sd_clock      (sd_clock),
        .reset         (reset),
        .req_in        (req_in),
        .req_write     (req_write),
        .req_blocks    (req_blocks),
        .req_timeout   (req_timeout),
        .ack_out       (ack_out),
        .status_out    (status_out),
        .busy_out      (busy_out),
        .strobe_out    (strobe_out),
        .blocks_out    (blocks_out),
        .writeRead_out (writeRead_out),
        .multiple_out  (multiple_out),
        .timeout_out   (timeout_out),
        .ack_phys_out  (ack_phys_out),
        .idle_phys_out (idle_phys_out),
        .block_done_in (block_done_in),
        .crc_err_in    (crc_err_in)
    );

    initial sd_clock = 1'b0;
    always #5 sd_clock = ~sd_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic wr, input logic [3:0] blocks, input logic [15:0] limit);
        req_in      = req;
        req_write   = wr;
        req_blocks  = blocks;
        req_timeout = limit;
    endtask

    task automatic tick();
        @(negedge sd_clock);
        if (strobe_out) strobeCnt++;
        if (ack_phys_out) ackPhysCnt++;
        if (idle_phys_out) idlePhysCnt++;
    endtask

    task automatic clearCounts();
        strobeCnt   = 0;
        ackPhysCnt  = 0;
        idlePhysCnt = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        reset         = 1'b1;
        block_done_in = 1'b0;
        crc_err_in    = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_idle_phys", 32'(idle_phys_out), 32'd1);
        checkOutput("rst_busy", 32'(busy_out), 32'd0);
        checkOutput("rst_ack", 32'(ack_out), 32'd0);
        checkOutput("rst_strobe", 32'(strobe_out), 32'd0);
        checkOutput("rst_status", 32'(status_out), 32'd0);
        checkOutput("rst_blocks", 32'(blocks_out), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_out), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("rel_idle_phys", 32'(idle_phys_out), 32'd0);

        $display("[TB] four-block write, 20-cycle block spacing");
        clearCounts();
        applyStimulus(1'b1, 1'b1, 4'd4, 16'd100);
        tick();
        checkOutput("t1_setup_busy", 32'(busy_out), 32'd1);
        checkOutput("t1_setup_strobe", 32'(strobe_out), 32'd0);
        checkOutput("t1_blocks", 32'(blocks_out), 32'd4);
        checkOutput("t1_write", 32'(writeRead_out), 32'd1);
        checkOutput("t1_multiple", 32'(multiple_out), 32'd1);
        checkOutput("t1_timeout", 32'(timeout_out), 32'd100);
        req_blocks = 4'd7;
        req_write  = 1'b0;
        tick();
        checkOutput("t1_strobe", 32'(strobe_out), 32'd1);
        tick();
        for (int b = 0; b < 4; b++) begin
            repeat (19) tick();
            block_done_in = 1'b1;
            tick();
            block_done_in = 1'b0;
        end
        checkOutput("t1_ack_phys", 32'(ack_phys_out), 32'd1);
        checkOutput("t1_blocks_stable", 32'(blocks_out), 32'd4);
        checkOutput("t1_write_stable", 32'(writeRead_out), 32'd1);
        tick();
        checkOutput("t1_ack", 32'(ack_out), 32'd1);
        checkOutput("t1_status", 32'(status_out), 32'd0);
        repeat (5) tick();
        checkOutput("t1_ack_held", 32'(ack_out), 32'd1);
        checkOutput("t1_strobe_count", 32'(strobeCnt), 32'd1);
        checkOutput("t1_ack_phys_count", 32'(ackPhysCnt), 32'd1);
        checkOutput("t1_idle_phys_count", 32'(idlePhysCnt), 32'd0);
        req_in = 1'b0;
        tick();
        checkOutput("t1_ack_drop", 32'(ack_out), 32'd0);
        checkOutput("t1_idle_busy", 32'(busy_out), 32'd0);
        checkOutput("t1_idle_status", 32'(status_out), 32'd0);

        $display("[TB] two-block read, watchdog expiry");
        clearCounts();
        applyStimulus(1'b1, 1'b0, 4'd2, 16'd100);
        tick();
        checkOutput("t2_read", 32'(writeRead_out), 32'd0);
        tick();
        tick();
        repeat (9) tick();
        block_done_in = 1'b1;
        tick();
        block_done_in = 1'b0;
        repeat (99) tick();
        checkOutput("t2_pre_abort_idle_phys", 32'(idle_phys_out), 32'd0);
        checkOutput("t2_pre_abort_busy", 32'(busy_out), 32'd1);
        checkOutput("t2_pre_abort_ack", 32'(ack_out), 32'd0);
        tick();
        checkOutput("t2_abort_idle_phys", 32'(idle_phys_out), 32'd1);
        tick();
        checkOutput("t2_ack", 32'(ack_out), 32'd1);
        checkOutput("t2_status", 32'(status_out), 32'd1);
        checkOutput("t2_idle_phys_count", 32'(idlePhysCnt), 32'd1);
        checkOutput("t2_ack_phys_count", 32'(ackPhysCnt), 32'd0);
        req_in = 1'b0;
        tick();

        $display("[TB] three-block write, CRC error with second block");
        clearCounts();
        applyStimulus(1'b1, 1'b1, 4'd3, 16'd100);
        tick();
        tick();
        tick();
        repeat (4) tick();
        block_done_in = 1'b1;
        tick();
        block_done_in = 1'b0;
        checkOutput("t3_count_one", 32'(dut.blkCnt_q), 32'd1);
        repeat (5) tick();
        block_done_in = 1'b1;
        crc_err_in    = 1'b1;
        tick();
        block_done_in = 1'b0;
        crc_err_in    = 1'b0;
        checkOutput("t3_abort_idle_phys", 32'(idle_phys_out), 32'd1);
        checkOutput("t3_count_held", 32'(dut.blkCnt_q), 32'd1);
        tick();
        checkOutput("t3_ack", 32'(ack_out), 32'd1);
        checkOutput("t3_status", 32'(status_out), 32'd2);
        req_in = 1'b0;
        tick();

        $display("[TB] zero-block request rejected");
        clearCounts();
        applyStimulus(1'b1, 1'b0, 4'd0, 16'd100);
        tick();
        checkOutput("t4_ack", 32'(ack_out), 32'd1);
        checkOutput("t4_status", 32'(status_out), 32'd3);
        tick();
        checkOutput("t4_no_strobe", 32'(strobeCnt), 32'd0);
        req_in = 1'b0;
        tick();
        checkOutput("t4_ack_drop", 32'(ack_out), 32'd0);
        checkOutput("t4_status_held", 32'(status_out), 32'd3);

        $display("[TB] watchdog disabled, then reset mid-transfer");
        clearCounts();
        applyStimulus(1'b1, 1'b1, 4'd2, 16'd0);
        tick();
        checkOutput("t5_timeout_zero", 32'(timeout_out), 32'd0);
        tick();
        tick();
        repeat (150) tick();
        checkOutput("t5_still_busy", 32'(busy_out), 32'd1);
        checkOutput("t5_no_abort", 32'(idlePhysCnt), 32'd0);
        reset  = 1'b1;
        req_in = 1'b0;
        #1;
        checkOutput("t5_rst_idle_phys_now", 32'(idle_phys_out), 32'd1);
        tick();
        checkOutput("t5_rst_idle_phys", 32'(idle_phys_out), 32'd1);
        checkOutput("t5_rst_busy", 32'(busy_out), 32'd0);
        checkOutput("t5_rst_status", 32'(status_out), 32'd0);
        checkOutput("t5_rst_blocks", 32'(blocks_out), 32'd0);
        checkOutput("t5_rst_write", 32'(writeRead_out), 32'd0);
        checkOutput("t5_rst_multiple", 32'(multiple_out), 32'd0);
        checkOutput("t5_rst_count", 32'(dut.blkCnt_q), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("t5_rel_idle_phys", 32'(idle_phys_out), 32'd0);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 4'd1, 16'd50);
        tick();
        checkOutput("t5_single_multiple", 32'(multiple_out), 32'd0);
        checkOutput("t5_single_blocks", 32'(blocks_out), 32'd1);
        tick();
        checkOutput("t5_strobe", 32'(strobe_out), 32'd1);
        tick();
        repeat (2) tick();
        block_done_in = 1'b1;
        tick();
        block_done_in = 1'b0;
        checkOutput("t5_ack_phys", 32'(ack_phys_out), 32'd1);
        tick();
        checkOutput("t5_ack", 32'(ack_out), 32'd1);
        checkOutput("t5_status", 32'(status_out), 32'd0);
        req_in = 1'b0;
        tick();
        checkOutput("t5_done_busy", 32'(busy_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dat_sequencer.md
DAT_SEQUENCER -- requirements
Module: dat_sequencer

Interface
REQ-001 SHALL have parameter BLK_W, default 4, meaning width of the block-count fields.
REQ-002 SHALL have parameter TO_W, default 16, meaning width of the timeout fields and the watchdog counter.
REQ-003 SHALL have port sd_clock  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous reset, active-high.
REQ-005 SHALL have port req_in  in  1  host transfer request, held high until ack_out.
REQ-006 SHALL have port req_write  in  1  direction: 1 = write to card, 0 = read.
REQ-007 SHALL have port req_blocks  in  BLK_W  number of blocks requested.
REQ-008 SHALL have port req_timeout  in  TO_W  per-block watchdog limit in sd_clock cycles.
REQ-009 SHALL have port ack_out  out  1  transfer finished; status_out valid.
REQ-010 SHALL have port status_out  out  2  00 OK, 01 TIMEOUT, 10 CRC_ERR, 11 REJECT.
REQ-011 SHALL have port busy_out  out  1  high in every state except IDLE.
REQ-012 SHALL have port strobe_out  out  1  one-cycle start pulse to dat_phys strobe_in.
REQ-013 SHALL have port blocks_out  out  BLK_W  latched block count to dat_phys blocks.
REQ-014 SHALL have port writeRead_out  out  1  latched direction to dat_phys writeRead.
REQ-015 SHALL have port multiple_out  out  1  1 when latched block count > 1.
REQ-016 SHALL have port timeout_out  out  TO_W  latched limit to dat_phys TIMEOUT_REG.
REQ-017 SHALL have port ack_phys_out  out  1  to dat_phys ack_in; completion acknowledge.
REQ-018 SHALL have port idle_phys_out  out  1  to dat_phys idle_in; forces PHY idle.
REQ-019 SHALL have port block_done_in  in  1  one-cycle pulse per block transferred.
REQ-020 SHALL have port crc_err_in  in  1  one-cycle pulse on CRC/CRC-status failure.

Function
REQ-021 SHALL implement states IDLE, SETUP, STROBE, WAIT_BLK, FINISH, ABORT, ACK_HOST.
REQ-022 IDLE: req_in=1 SHALL move to SETUP next cycle; req_blocks=0 SHALL go to ACK_HOST with status 11 instead.
REQ-023 SETUP SHALL latch req_write, req_blocks, req_timeout into blocks_out/writeRead_out/timeout_out/multiple_out, clear block counter and watchdog, then go to STROBE.
REQ-024 STROBE SHALL assert strobe_out for exactly one cycle (2 cycles after req_in sampled), then go to WAIT_BLK.
REQ-025 Latched outputs SHALL remain stable from SETUP until return to IDLE; host inputs ignored meanwhile.
REQ-026 WAIT_BLK: watchdog SHALL increment each cycle and clear on block_done_in.
REQ-027 block_done_in SHALL increment the block counter; when counter equals blocks_out, next state SHALL be FINISH.
REQ-028 crc_err_in SHALL go to ABORT with status 10; crc_err_in and block_done_in in the same cycle: CRC_ERR wins, counter not incremented.
REQ-029 Watchdog reaching timeout_out SHALL go to ABORT with status 01; block_done_in in that same cycle wins (no timeout).
REQ-030 timeout_out=0 SHALL disable the watchdog.
REQ-031 FINISH SHALL assert ack_phys_out one cycle, status 00, then ACK_HOST.
REQ-032 ABORT SHALL assert idle_phys_out one cycle, then ACK_HOST.
REQ-033 ACK_HOST SHALL hold ack_out=1 and status_out stable until req_in=0, then return to IDLE (four-phase handshake).
REQ-034 status_out SHALL hold its last value in IDLE.
REQ-035 Block counter SHALL be BLK_W bits and never wrap (exit at equality).

Reset
REQ-036 reset SHALL force IDLE; ack_out, busy_out, strobe_out, ack_phys_out=0; status_out=00; latched outputs and counters=0.
REQ-037 idle_phys_out SHALL be 1 while reset is high, including reset mid-transfer, and 0 the cycle after release.

Structure
REQ-038 State encodings and status codes SHALL live in the shared definitions file used by the CMD/DAT controllers.
REQ-039 Watchdog SHALL be a sub-module instance of the existing counter block; no other sub-modules.

Verification
REQ-040 req_blocks=4, write, 4 block_done pulses 20 cycles apart, timeout 100 -> one strobe, ack_phys_out once, ack_out with status 00, multiple_out=1.
REQ-041 req_blocks=2, timeout 100, one block_done then silence -> ABORT at 100 cycles after the last block_done, idle_phys_out pulse, status 01.
REQ-042 req_blocks=3, crc_err_in together with 2nd block_done -> status 10, counter remains 1.
REQ-043 req_blocks=0 -> no strobe_out, ack_out with status 11 within 2 cycles.
REQ-044 reset asserted in WAIT_BLK -> next cycle all outputs at reset values, idle_phys_out=1; new request after release completes normally.
REQ-045 req_in held high after ack_out -> ack_out stays high, no second strobe_out until req_in drops.
